move_sequencer: RTL and testbench

Turn and move controller for the Connect-4 game. Accepts a column selection plus a drop key, validates the move against per-column fill heights, and issues a single-cycle write to the board store. It then hands the placed cell to the external win checker and waits for the result. It owns `player` and `game_state` (the signals consumed by the HEX status display), ends the game on a win or a full board, and ignores input until reset.

---
 rtl/move_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_move_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
//
// Turn and move controller for a Connect-4 game. A rising edge on the drop key
// requests a move in the selected column. Legal moves are written to the board
// store with a single-cycle strobe, then handed to the external win checker.
// The block tracks per-column fill heights, the move count, the side to move
// and the overall game result. Once the game ends, input is ignored until
// reset.
//
// Parameters:
//   COLS        board columns; legal col values are 0..COLS-1
//   ROWS        board rows; row 0 is the bottom
//
// Ports:
//   clock       system clock, all state updates on posedge
//   reset       synchronous, active-high; restores start-of-game state
//   drop        debounced drop key (level); only a 0->1 edge requests a move
//   col         column selected by the switches, sampled on the drop edge
//   win_done    one-cycle pulse from the win checker: result valid
//   win_found   qualified by win_done: last move completed four in a row
//   wr_en       board write strobe, one cycle per accepted move
//   wr_row      row of the placed piece (held until the next accepted move)
//   wr_col      column of the placed piece (held the same way)
//   wr_player   colour written: 0 = red, 1 = green
//   check_start one-cycle request to the win checker
//   player      side to move: 0 = red, 1 = green
//   game_state  00 in progress, 01 red wins, 10 green wins, 11 tie
//   busy        high while a move is being written or checked
//   reject      one-cycle pulse for an illegal move request
// -----------------------------------------------------------------------------
module move_sequencer #(
   parameter int COLS = 7,
   parameter int ROWS = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       drop,
   input  logic [2:0] col,
   input  logic       win_done,
   input  logic       win_found,
   output logic       wr_en,
   output logic [2:0] wr_row,
   output logic [2:0] wr_col,
   output logic       wr_player,
   output logic       check_start,
   output logic       player,
   output logic [1:0] game_state,
   output logic       busy,
   output logic       reject
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_CHECK,
      S_WAIT,
      S_OVER
   } state_t;

   localparam logic [3:0] COLS_W = 4'(COLS);
   localparam logic [2:0] ROWS_H = 3'(ROWS);
   localparam logic [5:0] CELLS  = 6'(ROWS * COLS);

   localparam logic [1:0] GS_PLAY  = 2'b00;
   localparam logic [1:0] GS_RED   = 2'b01;
   localparam logic [1:0] GS_GREEN = 2'b10;
   localparam logic [1:0] GS_TIE   = 2'b11;

   state_t     state_q, state_d;
   logic [2:0] height_q [COLS];
   logic [2:0] height_d [COLS];
   logic [5:0] move_cnt_q, move_cnt_d;
   logic       drop_q;
   logic [2:0] wr_row_q, wr_row_d;
   logic [2:0] wr_col_q, wr_col_d;
   logic       wr_player_q, wr_player_d;
   logic       player_q, player_d;
   logic [1:0] game_state_q, game_state_d;
   logic       reject_q, reject_d;

   logic       drop_edge;
   logic       col_ok;
   logic [2:0] col_height;

   assign drop_edge = drop && !drop_q;
   assign col_ok    = {1'b0, col} < COLS_W;

   // Height of the selected column; an out-of-range column reads as 0 and is
   // rejected by col_ok anyway.
   always_comb begin
      col_height = '0;
      for (int i = 0; i < COLS; i++) begin
         if (col == 3'(i)) col_height = height_q[i];
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case statement so no
      // path leaves it unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      height_d     = height_q;
      move_cnt_d   = move_cnt_q;
      wr_row_d     = wr_row_q;
      wr_col_d     = wr_col_q;
      wr_player_d  = wr_player_q;
      player_d     = player_q;
      game_state_d = game_state_q;
      reject_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (drop_edge) begin
               if (col_ok && (col_height < ROWS_H)) begin
                  wr_col_d    = col;
                  wr_row_d    = col_height;
                  wr_player_d = player_q;
                  state_d     = S_WRITE;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end

         S_WRITE: begin
            for (int i = 0; i < COLS; i++) begin
               if (wr_col_q == 3'(i)) height_d[i] = height_q[i] + 3'd1;
            end
            move_cnt_d = move_cnt_q + 6'd1;
            state_d    = S_CHECK;
         end

         // A zero-wait checker may answer in the CHECK cycle itself, so both
         // states resolve the result the same way.
         S_CHECK, S_WAIT: begin
            state_d = S_WAIT;
            if (win_done) begin
               if (win_found) begin
                  game_state_d = wr_player_q ? GS_GREEN : GS_RED;
                  state_d      = S_OVER;
               end else if (move_cnt_q == CELLS) begin
                  game_state_d = GS_TIE;
                  state_d      = S_OVER;
               end else begin
                  player_d = ~player_q;
                  state_d  = S_IDLE;
               end
            end
         end

         S_OVER: begin
            // Frozen until reset; drop edges are silently ignored.
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its _d value from before this edge, regardless of order.
      if (reset) begin
         state_q      <= S_IDLE;
         // NOTE: the height table is a handful of flops that must read zero
         // at game start, so it is reset like any other state, not treated
         // as an uninitialised RAM.
         for (int i = 0; i < COLS; i++) height_q[i] <= '0;
         move_cnt_q   <= '0;
         drop_q       <= 1'b0;
         wr_row_q     <= '0;
         wr_col_q     <= '0;
         wr_player_q  <= 1'b0;
         player_q     <= 1'b0;
         game_state_q <= GS_PLAY;
         reject_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         height_q     <= height_d;
         move_cnt_q   <= move_cnt_d;
         drop_q       <= drop;
         wr_row_q     <= wr_row_d;
         wr_col_q     <= wr_col_d;
         wr_player_q  <= wr_player_d;
         player_q     <= player_d;
         game_state_q <= game_state_d;
         reject_q     <= reject_d;
      end
   end

   // Outputs are either flops or pure decodes of the state register.
   assign wr_en       = (state_q == S_WRITE);
   assign check_start = (state_q == S_CHECK);
   assign busy        = (state_q == S_WRITE) || (state_q == S_CHECK) ||
                        (state_q == S_WAIT);
   assign wr_row      = wr_row_q;
   assign wr_col      = wr_col_q;
   assign wr_player   = wr_player_q;
   assign player      = player_q;
   assign game_state  = game_state_q;
   assign reject      = reject_q;

endmodule

// File: tb/tb_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_move_sequencer
//
// Self-checking bench for move_sequencer. A small game model predicts each
// write (row, column, colour) and pushes it to a scoreboard queue when the
// drop is driven; a monitor pops and compares on every wr_en cycle. Turn,
// result, reject and busy behaviour are compared against the model inline.
// -----------------------------------------------------------------------------
module tb_move_sequencer;

   typedef struct packed {
      logic [2:0] row;
      logic [2:0] col;
      logic       pl;
   } wr_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       drop;
   logic [2:0] col;
   logic       win_done;
   logic       win_found;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [2:0] wr_col;
   logic       wr_player;
   logic       check_start;
   logic       player;
   logic [1:0] game_state;
   logic       busy;
   logic       reject;

   int n_checks = 0;
   int n_pass   = 0;
   int n_wr     = 0;

   wr_t sb[$];

   // Reference model of the game.
   int         m_height [8];
   int         m_cnt;
   logic       m_player;
   logic [1:0] m_gs;

   move_sequencer #(.COLS(7), .ROWS(6)) dut (
      .clock      (clock),
      .reset      (reset),
      .drop       (drop),
      .col        (col),
      .win_done   (win_done),
      .win_found  (win_found),
      .wr_en      (wr_en),
      .wr_row     (wr_row),
      .wr_col     (wr_col),
      .wr_player  (wr_player),
      .check_start(check_start),
      .player     (player),
      .game_state (game_state),
      .busy       (busy),
      .reject     (reject)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard monitor: every write strobe must match the oldest prediction.
   always @(negedge clock) begin
      if (wr_en === 1'b1) begin
         n_wr++;
         if (sb.size() == 0) begin
            check("sb_unexpected_wr", 32'(wr_col), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("sb_row", 32'(wr_row), 32'(e.row));
            check("sb_col", 32'(wr_col), 32'(e.col));
            check("sb_player", 32'(wr_player), 32'(e.pl));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_height[i] = 0;
      m_cnt    = 0;
      m_player = 1'b0;
      m_gs     = 2'b00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drop = 1'b0;
      win_done = 1'b0;
      win_found = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   // Resolve a checker answer in the model.
   task automatic model_resolve(input logic wf);
      if (wf) m_gs = m_player ? 2'b10 : 2'b01;
      else if (m_cnt == 42) m_gs = 2'b11;
      else m_player = ~m_player;
   endtask

   // One drop request; the checker answers after wait_n cycles in WAIT.
   task automatic play(input logic [2:0] c, input logic wf, input int wait_n);
      bit over;
      bit legal;
      over  = (m_gs != 2'b00);
      legal = (int'(c) < 7) && (m_height[c] < 6);
      col  = c;
      drop = 1'b1;
      if (!over && legal) sb.push_back('{row: 3'(m_height[c]), col: c, pl: m_player});
      tick();
      if (over) begin
         check("over_wr_en", 32'(wr_en), 0);
         check("over_reject", 32'(reject), 0);
         drop = 1'b0;
         tick();
         check("over_gs_frozen", 32'(game_state), 32'(m_gs));
         check("over_player_frozen", 32'(player), 32'(m_player));
      end else if (!legal) begin
         check("illegal_reject", 32'(reject), 1);
         check("illegal_wr_en", 32'(wr_en), 0);
         check("illegal_busy", 32'(busy), 0);
         drop = 1'b0;
         tick();
         check("illegal_reject_len", 32'(reject), 0);
         check("illegal_player", 32'(player), 32'(m_player));
      end else begin
         check("move_wr_en", 32'(wr_en), 1);
         check("move_busy", 32'(busy), 1);
         drop = 1'b0;
         tick();
         check("move_check_start", 32'(check_start), 1);
         check("move_wr_en_len", 32'(wr_en), 0);
         m_height[c]++;
         m_cnt++;
         for (int i = 0; i < wait_n; i++) tick();
         if (wait_n > 0) check("wait_busy", 32'(busy), 1);
         win_done  = 1'b1;
         win_found = wf;
         tick();
         win_done  = 1'b0;
         win_found = 1'b0;
         model_resolve(wf);
         check("move_busy_fall", 32'(busy), 0);
         check("move_player", 32'(player), 32'(m_player));
         check("move_game_state", 32'(game_state), 32'(m_gs));
      end
   endtask

   initial begin
      int wr_before;
      reset = 1'b1;
      drop = 1'b0;
      col = 3'd0;
      win_done = 1'b0;
      win_found = 1'b0;
      do_reset();

      // Reset values.
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_check_start", 32'(check_start), 0);
      check("rst_reject", 32'(reject), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_player", 32'(player), 0);
      check("rst_game_state", 32'(game_state), 0);
      check("rst_wr_row", 32'(wr_row), 0);
      check("rst_wr_col", 32'(wr_col), 0);
      check("rst_wr_player", 32'(wr_player), 0);

      // First move, zero-wait checker.
      play(3'd3, 1'b0, 0);
      check("first_player", 32'(player), 1);

      // Seven drops into column 0; the seventh is rejected.
      do_reset();
      for (int i = 0; i < 7; i++) play(3'd0, 1'b0, i % 3);

      // Out-of-range column, then prove heights/counter untouched.
      play(3'd7, 1'b0, 0);
      play(3'd1, 1'b0, 1);

      // Held key fires exactly once.
      wr_before = n_wr;
      col  = 3'd2;
      drop = 1'b1;
      sb.push_back('{row: 3'(m_height[2]), col: 3'd2, pl: m_player});
      tick();
      check("hold_wr_en", 32'(wr_en), 1);
      tick();
      win_done = 1'b1;
      tick();
      win_done = 1'b0;
      m_height[2]++;
      m_cnt++;
      model_resolve(1'b0);
      for (int i = 0; i < 17; i++) tick();
      check("hold_single_write", 32'(n_wr - wr_before), 1);
      check("hold_player", 32'(player), 32'(m_player));
      drop = 1'b0;
      tick();

      // Red wins; further drops ignored; reset restores.
      do_reset();
      play(3'd5, 1'b1, 2);
      check("red_win_gs", 32'(game_state), 32'b01);
      wr_before = n_wr;
      play(3'd1, 1'b0, 0);
      play(3'd7, 1'b0, 0);
      check("over_no_writes", 32'(n_wr - wr_before), 0);
      do_reset();
      check("after_win_rst_gs", 32'(game_state), 0);
      check("after_win_rst_player", 32'(player), 0);

      // Full board, tie.
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++) play(3'(c), 1'b0, r % 3);
      check("tie_gs", 32'(game_state), 32'b11);
      play(3'd0, 1'b0, 0);

      // Full board, green wins on the 42nd move (win beats tie).
      do_reset();
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++) play(3'(c), (c == 6 && r == 5), 0);
      check("green_win_gs", 32'(game_state), 32'b10);

      // Reset during WAIT with a simultaneous win_done.
      do_reset();
      col  = 3'd4;
      drop = 1'b1;
      sb.push_back('{row: 3'd0, col: 3'd4, pl: 1'b0});
      tick();
      drop = 1'b0;
      tick();
      tick();
      check("rw_busy_wait", 32'(busy), 1);
      reset     = 1'b1;
      win_done  = 1'b1;
      win_found = 1'b1;
      tick();
      reset     = 1'b0;
      win_done  = 1'b0;
      win_found = 1'b0;
      model_reset();
      check("rw_gs", 32'(game_state), 0);
      check("rw_player", 32'(player), 0);
      check("rw_busy", 32'(busy), 0);
      check("rw_wr_row", 32'(wr_row), 0);
      check("rw_wr_col", 32'(wr_col), 0);
      play(3'd4, 1'b0, 1);

      tick();
      check("sb_empty", 32'(sb.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
